// File: rtl/caliptra_apb_arb_pkg.sv
// Shared types and helpers for the Caliptra APB N:1 arbiter/mux.
// No logic of its own; imported by the arbiter and the top.
package caliptra_apb_arb_pkg;

    localparam int APB_PROT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    function automatic int GRANT_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/caliptra_rr_arbiter.sv
// Combinational round-robin pick; search starts one past rr_ptr and wraps.
// Zero latency; holds no state, so the caller owns pointer update and backpressure.
module caliptra_rr_arbiter
    import caliptra_apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [GRANT_W(NUM_REQ)-1:0] rr_ptr,
    output logic [GRANT_W(NUM_REQ)-1:0] grant,
    output logic                        valid
);
    localparam int GW = GRANT_W(NUM_REQ);

    logic [GW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = GW'((int'(rr_ptr) + 1 + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/caliptra_apb_arb_mux.sv
// Round-robin NUM_REQ:1 APB4 arbiter/mux; ACCESS watchdog built in with CALIPTRA_APB_ARB_TIMEOUT_EN.
// psel->pready 3 cycles plus completer waits; losing requesters stall in their access phase.
module caliptra_apb_arb_mux
    import caliptra_apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           core_clk,
    input  logic                           core_rst,
    input  logic [NUM_REQ-1:0]             s_apb_psel,
    input  logic [NUM_REQ-1:0]             s_apb_penable,
    input  logic [NUM_REQ-1:0]             s_apb_pwrite,
    input  logic [NUM_REQ*ADDR_W-1:0]      s_apb_paddr,
    input  logic [NUM_REQ*DATA_W-1:0]      s_apb_pwdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]    s_apb_pstrb,
    input  logic [NUM_REQ*APB_PROT_W-1:0]  s_apb_pprot,
    output logic [NUM_REQ*DATA_W-1:0]      s_apb_prdata,
    output logic [NUM_REQ-1:0]             s_apb_pready,
    output logic [NUM_REQ-1:0]             s_apb_pslverr,
    output logic                           m_apb_psel,
    output logic                           m_apb_penable,
    output logic                           m_apb_pwrite,
    output logic [ADDR_W-1:0]              m_apb_paddr,
    output logic [DATA_W-1:0]              m_apb_pwdata,
    output logic [DATA_W/8-1:0]            m_apb_pstrb,
    output logic [APB_PROT_W-1:0]          m_apb_pprot,
    input  logic [DATA_W-1:0]              m_apb_prdata,
    input  logic                           m_apb_pready,
    input  logic                           m_apb_pslverr
);
    localparam int STRB_W = DATA_W / 8;
    localparam int GW     = GRANT_W(NUM_REQ);

    arb_state_e state, state_n;

    logic [GW-1:0]         grant, grant_n, rr_ptr, rr_ptr_n, arb_grant;
    logic                  arb_vld;
    logic                  drop, drop_n;
    logic                  write_n;
    logic [ADDR_W-1:0]     addr_n;
    logic [DATA_W-1:0]     wdata_n;
    logic [STRB_W-1:0]     strb_n;
    logic [APB_PROT_W-1:0] prot_n;
    logic [DATA_W-1:0]     rsp_data_n;
    logic                  rsp_err_n;
    logic [NUM_REQ-1:0]    rsp_sel;
    logic                  timeout_hit;

    logic [ADDR_W-1:0]     req_addr  [NUM_REQ];
    logic [DATA_W-1:0]     req_wdata [NUM_REQ];
    logic [STRB_W-1:0]     req_strb  [NUM_REQ];
    logic [APB_PROT_W-1:0] req_prot  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_addr[g]  = s_apb_paddr[g*ADDR_W +: ADDR_W];
        assign req_wdata[g] = s_apb_pwdata[g*DATA_W +: DATA_W];
        assign req_strb[g]  = s_apb_pstrb[g*STRB_W +: STRB_W];
        assign req_prot[g]  = s_apb_pprot[g*APB_PROT_W +: APB_PROT_W];
    end

    // Requester penable only matters to the requester's own protocol.
    logic unused_penable;
    assign unused_penable = ^s_apb_penable;

    caliptra_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req    (s_apb_psel),
        .rr_ptr (rr_ptr),
        .grant  (arb_grant),
        .valid  (arb_vld)
    );

`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge core_clk) begin
        if (core_rst || state != ACCESS) begin
            to_cnt <= '0;
        end else if (!m_apb_pready) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        grant_n    = grant;
        rr_ptr_n   = rr_ptr;
        drop_n     = drop;
        write_n    = m_apb_pwrite;
        addr_n     = m_apb_paddr;
        wdata_n    = m_apb_pwdata;
        strb_n     = m_apb_pstrb;
        prot_n     = m_apb_pprot;
        rsp_data_n = '0;
        rsp_err_n  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_vld) begin
                    state_n = SETUP;
                    grant_n = arb_grant;
                    drop_n  = 1'b0;
                    write_n = s_apb_pwrite[arb_grant];
                    addr_n  = req_addr[arb_grant];
                    wdata_n = req_wdata[arb_grant];
                    strb_n  = req_strb[arb_grant];
                    prot_n  = req_prot[arb_grant];
                end
            end
            SETUP: begin
                state_n = ACCESS;
                drop_n  = drop | ~s_apb_psel[grant];
            end
            ACCESS: begin
                // A requester that abandons its transfer still lets the completer finish.
                drop_n = drop | ~s_apb_psel[grant];
                if (m_apb_pready) begin
                    rsp_data_n = m_apb_prdata;
                    rsp_err_n  = m_apb_pslverr;
                    rr_ptr_n   = grant;
                    state_n    = RESP;
                end else if (timeout_hit) begin
                    rsp_err_n = 1'b1;
                    rr_ptr_n  = grant;
                    state_n   = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        rsp_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_sel[i] = (state_n == RESP) && !drop_n && (grant_n == GW'(i));
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            grant         <= '0;
            rr_ptr        <= GW'(NUM_REQ - 1);
            drop          <= 1'b0;
            m_apb_psel    <= 1'b0;
            m_apb_penable <= 1'b0;
            m_apb_pwrite  <= 1'b0;
            m_apb_paddr   <= '0;
            m_apb_pwdata  <= '0;
            m_apb_pstrb   <= '0;
            m_apb_pprot   <= '0;
            s_apb_pready  <= '0;
            s_apb_pslverr <= '0;
            s_apb_prdata  <= '0;
        end else begin
            grant         <= grant_n;
            rr_ptr        <= rr_ptr_n;
            drop          <= drop_n;
            m_apb_psel    <= (state_n == SETUP) || (state_n == ACCESS);
            m_apb_penable <= (state_n == ACCESS);
            m_apb_pwrite  <= write_n;
            m_apb_paddr   <= addr_n;
            m_apb_pwdata  <= wdata_n;
            m_apb_pstrb   <= strb_n;
            m_apb_pprot   <= prot_n;
            s_apb_pready  <= rsp_sel;
            s_apb_pslverr <= rsp_sel & {NUM_REQ{rsp_err_n}};
            for (int i = 0; i < NUM_REQ; i++) begin
                s_apb_prdata[i*DATA_W +: DATA_W] <= rsp_sel[i] ? rsp_data_n : '0;
            end
        end
    end

endmodule

// File: tb/tb_caliptra_apb_arb_mux.sv
// Directed bench for caliptra_apb_arb_mux with two requesters and a wait-state completer model.
module tb_caliptra_apb_arb_mux;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic core_clk = 1'b0;
    logic core_rst = 1'b1;
    always #5 core_clk = ~core_clk;

    logic [N-1:0]    s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
    logic [N*AW-1:0] s_paddr;
    logic [N*DW-1:0] s_pwdata, s_prdata;
    logic [N*SW-1:0] s_pstrb;
    logic [N*3-1:0]  s_pprot;
    logic            m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
    logic [AW-1:0]   m_paddr;
    logic [DW-1:0]   m_pwdata, m_prdata;
    logic [SW-1:0]   m_pstrb;
    logic [2:0]      m_pprot;

    caliptra_apb_arb_mux #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .s_apb_psel(s_psel), .s_apb_penable(s_penable), .s_apb_pwrite(s_pwrite),
        .s_apb_paddr(s_paddr), .s_apb_pwdata(s_pwdata), .s_apb_pstrb(s_pstrb),
        .s_apb_pprot(s_pprot), .s_apb_prdata(s_prdata), .s_apb_pready(s_pready),
        .s_apb_pslverr(s_pslverr),
        .m_apb_psel(m_psel), .m_apb_penable(m_penable), .m_apb_pwrite(m_pwrite),
        .m_apb_paddr(m_paddr), .m_apb_pwdata(m_pwdata), .m_apb_pstrb(m_pstrb),
        .m_apb_pprot(m_pprot), .m_apb_prdata(m_prdata), .m_apb_pready(m_pready),
        .m_apb_pslverr(m_pslverr)
    );

    // Completer: ready after cpl_waits ACCESS wait states, never when hung.
    int            cpl_waits = 0;
    bit            cpl_hang  = 1'b0;
    logic [DW-1:0] cpl_rdata = '0;
    bit            cpl_err   = 1'b0;
    int            wcnt      = 0;
    int            cpl_count = 0;
    logic [AW-1:0] cap_addr  = '0;
    logic [DW-1:0] cap_wdata = '0;
    logic [SW-1:0] cap_strb  = '0;
    logic [2:0]    cap_prot  = '0;
    logic          cap_write = 1'b0;

    assign m_pready  = m_psel && m_penable && !cpl_hang && (wcnt == cpl_waits);
    assign m_prdata  = cpl_rdata;
    assign m_pslverr = m_pready && cpl_err;

    always @(posedge core_clk) begin
        if (m_psel && m_penable && !m_pready) wcnt <= wcnt + 1;
        else                                  wcnt <= 0;
        if (m_pready) begin
            cpl_count <= cpl_count + 1;
            cap_addr  <= m_paddr;
            cap_wdata <= m_pwdata;
            cap_strb  <= m_pstrb;
            cap_prot  <= m_pprot;
            cap_write <= m_pwrite;
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic drive(input int r, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] st, input logic [2:0] p);
        s_pwrite[r]          = wr;
        s_paddr[r*AW +: AW]  = a;
        s_pwdata[r*DW +: DW] = d;
        s_pstrb[r*SW +: SW]  = st;
        s_pprot[r*3 +: 3]    = p;
        s_psel[r]            = 1'b1;
        s_penable[r]         = 1'b1;
    endtask

    typedef struct {
        int            req;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        int            waits;
        logic [DW-1:0] rdata;
        bit            err;
        int            exp_rdy;
    } vec_t;

    vec_t vecs[4];

    task automatic run_vec(input int k, input vec_t v);
        int psel_cyc, pen_cyc, rdy_cyc, rdy_cnt, base;
        bit other_bad;
        logic [DW-1:0] got_data;
        logic got_err;
        psel_cyc = -1; pen_cyc = -1; rdy_cyc = -1; rdy_cnt = 0;
        other_bad = 1'b0; got_data = '0; got_err = 1'b0;
        cpl_waits = v.waits; cpl_rdata = v.rdata; cpl_err = v.err; cpl_hang = 1'b0;
        @(negedge core_clk);
        base = cpl_count;
        drive(v.req, v.wr, v.addr, v.wdata, v.strb, v.prot);
        for (int c = 0; c <= v.exp_rdy + 4; c++) begin
            if (c > 0) @(negedge core_clk);
            if (m_psel && psel_cyc < 0) psel_cyc = c;
            if (m_penable && pen_cyc < 0) pen_cyc = c;
            if (s_pready[v.req]) begin
                rdy_cnt++;
                if (rdy_cyc < 0) begin
                    rdy_cyc  = c;
                    got_data = s_prdata[v.req*DW +: DW];
                    got_err  = s_pslverr[v.req];
                    s_psel[v.req]    = 1'b0;
                    s_penable[v.req] = 1'b0;
                end
            end
            for (int j = 0; j < N; j++) begin
                if (j != v.req && (s_pready[j] || s_pslverr[j] || s_prdata[j*DW +: DW] != '0))
                    other_bad = 1'b1;
            end
        end
        s_psel[v.req]    = 1'b0;
        s_penable[v.req] = 1'b0;
        check($sformatf("v%0d_m_psel_cycle", k), psel_cyc, 1);
        check($sformatf("v%0d_m_penable_cycle", k), pen_cyc, 2);
        check($sformatf("v%0d_s_pready_cycle", k), rdy_cyc, v.exp_rdy);
        check($sformatf("v%0d_s_pready_pulses", k), rdy_cnt, 1);
        check($sformatf("v%0d_s_prdata", k), got_data, v.rdata);
        check($sformatf("v%0d_s_pslverr", k), got_err, v.err);
        check($sformatf("v%0d_other_req_quiet", k), other_bad, 0);
        check($sformatf("v%0d_cpl_xfers", k), cpl_count - base, 1);
        check($sformatf("v%0d_m_paddr", k), cap_addr, v.addr);
        check($sformatf("v%0d_m_pwrite", k), cap_write, v.wr);
        check($sformatf("v%0d_m_pwdata", k), cap_wdata, v.wdata);
        check($sformatf("v%0d_m_pstrb", k), cap_strb, v.strb);
        check($sformatf("v%0d_m_pprot", k), cap_prot, v.prot);
    endtask

    int order[$];
    int ocyc[$];
    bit overlap;

    // Observe pready winners; drops every psel once n responses have been seen.
    task automatic collect(input int n, input int budget);
        order.delete();
        ocyc.delete();
        overlap = 1'b0;
        for (int c = 0; c < budget && order.size() < n; c++) begin
            if (c > 0) @(negedge core_clk);
            if (s_pready[0] && s_pready[1]) overlap = 1'b1;
            for (int j = 0; j < N; j++) begin
                if (s_pready[j]) begin
                    order.push_back(j);
                    ocyc.push_back(c);
                end
            end
            if (order.size() >= n) begin
                s_psel    = '0;
                s_penable = '0;
            end
        end
        s_psel    = '0;
        s_penable = '0;
    endtask

    function automatic int ord(input int i);
        return (i < order.size()) ? order[i] : -1;
    endfunction

    function automatic int ocy(input int i);
        return (i < ocyc.size()) ? ocyc[i] : -1;
    endfunction

    int            base_cnt;
    bit            saw;
    int            rdy_c;
    logic          t_err, t_psel;
    logic [DW-1:0] t_data;

    initial begin
        s_psel = '0; s_penable = '0; s_pwrite = '0;
        s_paddr = '0; s_pwdata = '0; s_pstrb = '0; s_pprot = '0;

        vecs[0] = '{0, 1'b1, 32'h3002_0000, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 32'h0000_0000, 1'b0, 3};
        vecs[1] = '{1, 1'b0, 32'h3002_0010, 32'h0000_0000, 4'h0, 3'd1, 3, 32'h1234_5678, 1'b0, 6};
        vecs[2] = '{1, 1'b1, 32'h3003_0004, 32'h0000_A5A5, 4'h3, 3'd5, 1, 32'h0000_0055, 1'b1, 4};
        vecs[3] = '{0, 1'b0, 32'h3002_1FFC, 32'h0000_0000, 4'h0, 3'd2, 2, 32'hCAFE_F00D, 1'b0, 5};

        repeat (3) @(negedge core_clk);
        check("rst_m_psel", m_psel, 0);
        check("rst_m_penable", m_penable, 0);
        check("rst_m_pwrite", m_pwrite, 0);
        check("rst_m_paddr", m_paddr, 0);
        check("rst_m_pwdata_strb_prot", {m_pwdata, m_pstrb, m_pprot}, 0);
        check("rst_s_pready", s_pready, 0);
        check("rst_s_pslverr", s_pslverr, 0);
        check("rst_s_prdata", s_prdata, 0);
        core_rst = 1'b0;
        repeat (2) @(negedge core_clk);
        check("idle_no_req_m_psel", m_psel, 0);

        for (int k = 0; k < 4; k++) run_vec(k, vecs[k]);

        // Both requesters held from reset release: strict rotation at 4-cycle spacing.
        cpl_waits = 0; cpl_err = 1'b0; cpl_rdata = 32'h0000_0001;
        core_rst = 1'b1;
        drive(0, 1'b1, 32'h3002_0100, 32'h1111_1111, 4'hF, 3'd0);
        drive(1, 1'b1, 32'h3002_0200, 32'h2222_2222, 4'hF, 3'd0);
        repeat (2) @(negedge core_clk);
        core_rst = 1'b0;
        collect(4, 80);
        for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), ord(i), i % 2);
        check("rr_first_cycle", ocy(0), 3);
        check("rr_spacing", ocy(1) - ocy(0), 4);
        check("rr_no_overlap", overlap, 0);

        // Granted requester abandons mid-ACCESS: completer finishes, no pready, pointer moves.
        repeat (2) @(negedge core_clk);
        cpl_waits = 2; cpl_rdata = 32'h0BAD_0BAD;
        base_cnt = cpl_count;
        saw = 1'b0;
        drive(0, 1'b0, 32'h3002_0040, 32'h0, 4'h0, 3'd0);
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge core_clk);
            if (c == 2) begin
                s_psel[0]    = 1'b0;
                s_penable[0] = 1'b0;
            end
            if (|s_pready) saw = 1'b1;
        end
        check("drop_no_pready", saw, 0);
        check("drop_cpl_completed", cpl_count - base_cnt, 1);
        cpl_waits = 0;
        drive(0, 1'b0, 32'h3002_0300, 32'h0, 4'h0, 3'd0);
        drive(1, 1'b0, 32'h3002_0400, 32'h0, 4'h0, 3'd0);
        collect(2, 40);
        check("drop_rr_next0", ord(0), 1);
        check("drop_rr_next1", ord(1), 0);

        // Reset during ACCESS: outputs clear next edge, requester 0 wins afterwards.
        repeat (2) @(negedge core_clk);
        cpl_hang = 1'b1;
        drive(1, 1'b0, 32'h3002_0500, 32'h0, 4'h0, 3'd0);
        saw = 1'b0;
        for (int c = 0; c < 20 && !saw; c++) begin
            @(negedge core_clk);
            if (m_penable) saw = 1'b1;
        end
        check("rst_mid_access_reached", saw, 1);
        core_rst = 1'b1;
        drive(0, 1'b0, 32'h3002_0600, 32'h0, 4'h0, 3'd0);
        @(negedge core_clk);
        check("rst_mid_m_psel", m_psel, 0);
        check("rst_mid_m_penable", m_penable, 0);
        check("rst_mid_s_pready", s_pready, 0);
        cpl_hang = 1'b0;
        @(negedge core_clk);
        core_rst = 1'b0;
        collect(1, 20);
        check("rst_rr_first_grant", ord(0), 0);
        check("rst_rr_first_cycle", ocy(0), 3);

        repeat (2) @(negedge core_clk);
`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
        cpl_hang = 1'b1; cpl_rdata = 32'hFFFF_FFFF; cpl_err = 1'b0;
        drive(0, 1'b0, 32'h3002_0080, 32'h0, 4'h0, 3'd0);
        rdy_c = -1; t_err = 1'b0; t_data = '1; t_psel = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            if (c > 0) @(negedge core_clk);
            if (s_pready[0] && rdy_c < 0) begin
                rdy_c  = c;
                t_err  = s_pslverr[0];
                t_data = s_prdata[DW-1:0];
                t_psel = m_psel;
                s_psel[0]    = 1'b0;
                s_penable[0] = 1'b0;
            end
        end
        s_psel = '0; s_penable = '0;
        check("timeout_rdy_cycle", rdy_c, 18);
        check("timeout_pslverr", t_err, 1);
        check("timeout_prdata", t_data, 0);
        check("timeout_m_psel_dropped", t_psel, 0);
        cpl_hang = 1'b0;
`else
        cpl_hang = 1'b1;
        drive(0, 1'b0, 32'h3002_0080, 32'h0, 4'h0, 3'd0);
        saw = 1'b0;
        repeat (1000) begin
            @(negedge core_clk);
            if (|s_pready) saw = 1'b1;
        end
        check("no_timeout_no_pready", saw, 0);
        check("no_timeout_still_access", {m_psel, m_penable}, 2'b11);
        core_rst = 1'b1;
        s_psel = '0; s_penable = '0;
        repeat (2) @(negedge core_clk);
        core_rst = 1'b0;
        cpl_hang = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/caliptra_apb_arb_mux.md
Name: caliptra_apb_arb_mux

Overview:
- Parametrised N-requester to 1-completer APB4 arbiter and multiplexer for the FPGA build.
- Lets several APB requesters share the single Caliptra APB completer port. Typical requesters are the PS host, a JTAG-to-APB debug path and a BRAM-driven boot sequencer.
- Round-robin arbitration, one transfer at a time, registered completer-side and response-side signals.
- Generalises the single-requester APB top to NUM_REQ channels.

Parameters:
- NUM_REQ, 2: number of requester channels, 1..8.
- ADDR_W, 32: APB address width.
- DATA_W, 32: APB data width, multiple of 8. STRB_W = DATA_W/8.
- TIMEOUT_CYCLES, 256: ACCESS-phase watchdog limit. Used only when the optional feature is compiled in.

Ports:
core_clk  in  1  single clock for all logic.
core_rst  in  1  synchronous active-high reset.
s_apb_psel  in  NUM_REQ  per-requester select.
s_apb_penable  in  NUM_REQ  per-requester enable.
s_apb_pwrite  in  NUM_REQ  per-requester write flag.
s_apb_paddr  in  NUM_REQ*ADDR_W  packed addresses; slice i belongs to requester i.
s_apb_pwdata  in  NUM_REQ*DATA_W  packed write data.
s_apb_pstrb  in  NUM_REQ*STRB_W  packed write strobes.
s_apb_pprot  in  NUM_REQ*3  packed protection bits.
s_apb_prdata  out  NUM_REQ*DATA_W  packed read data.
s_apb_pready  out  NUM_REQ  per-requester ready.
s_apb_pslverr  out  NUM_REQ  per-requester error.
m_apb_psel  out  1  completer select.
m_apb_penable  out  1  completer enable.
m_apb_pwrite  out  1  completer write flag.
m_apb_paddr  out  ADDR_W  completer address.
m_apb_pwdata  out  DATA_W  completer write data.
m_apb_pstrb  out  STRB_W  completer strobes.
m_apb_pprot  out  3  completer protection bits.
m_apb_prdata  in  DATA_W  completer read data.
m_apb_pready  in  1  completer ready.
m_apb_pslverr  in  1  completer error.

Behaviour:
- Reset state: every output is 0, FSM is IDLE, rr_ptr = NUM_REQ-1 so requester 0 wins first. Reset takes effect on the next core_clk edge from any state. An in-flight completer transfer is abandoned and no requester receives pready.

- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any s_apb_psel bit is set, pick the winner by round-robin, starting at index (rr_ptr+1) mod NUM_REQ and ascending with wrap.
  - Latch the winner's index (grant), pwrite, paddr, pwdata, pstrb and pprot, then go to SETUP.
  - If no psel bit is set, stay in IDLE.
- SETUP: m_apb_psel=1, m_apb_penable=0. Go to ACCESS. m_apb_pready is ignored in this state.
- ACCESS: m_apb_psel=1, m_apb_penable=1. Stay until m_apb_pready=1. On that cycle:
  - capture m_apb_prdata and m_apb_pslverr;
  - set rr_ptr = grant;
  - go to RESP.
- RESP: for exactly one cycle drive s_apb_pready[grant]=1, the prdata slice of grant = captured data, and s_apb_pslverr[grant] = captured error. m_apb_psel and m_apb_penable are 0. Go to IDLE.

- Data and output rules:
  - m_apb_paddr, m_apb_pwdata, m_apb_pstrb, m_apb_pprot and m_apb_pwrite come from the latched registers.
  - The latched registers are stable from SETUP through ACCESS.
  - The captured data is forwarded for reads and writes alike.
  - Non-granted requesters always see pready=0, prdata=0 and pslverr=0. Requesters that are not granted stall in their own access phase.
  - Requester penable is not used for arbitration.

- Latency, zero-wait completer: requester psel in cycle 0, m_psel in cycle 1, m_penable in cycle 2, s_pready in cycle 3. Each completer wait state adds 1 cycle.
- Minimum spacing between two granted transfers is 4 cycles (RESP to IDLE to SETUP).
- Fairness: requests present simultaneously on every IDLE cycle are served in strict rotation (0,1,...,N-1,0).
- Protocol violation: if the granted requester drops psel mid-transfer, the completer transfer still completes. The response is discarded and no pready is driven. rr_ptr still advances.
- NUM_REQ=1: grant width is 1 bit and the block behaves as a registered APB pipeline stage.

Optional Feature:
- Macro: CALIPTRA_APB_ARB_TIMEOUT_EN.
- Compiled in:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle while m_apb_pready=0.
  - When the count reaches TIMEOUT_CYCLES, the block drops m_apb_psel and m_apb_penable and goes to RESP with pslverr=1 and prdata=0. rr_ptr advances.
  - pready arriving on the same cycle as the timeout wins; the response is normal.
- Compiled out: no counter, and ACCESS waits indefinitely.

Decomposition:
- Package caliptra_apb_arb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - a GRANT_W function: max(1, clog2(NUM_REQ));
  - the APB_PROT_W=3 constant.
- Sub-module caliptra_rr_arbiter:
  - combinational round-robin pick;
  - inputs: request vector and rr_ptr;
  - outputs: grant index and valid.

Test Plan:
1. Requester 0 writes 0x3002_0000 = 0xDEADBEEF with pstrb 0xF, zero-wait completer -> m_psel in cycle 1, m_penable in cycle 2, s_pready[0]=1 in cycle 3 only, s_pslverr=0, completer sees exact addr/data/strb.
2. Requester 1 reads with 3 wait states, completer returns 0x1234_5678 -> s_pready[1] pulses in cycle 6, prdata slice 1 = 0x12345678, slice 0 = 0.
3. Both requesters hold psel continuously from reset release -> grants are 0,1,0,1 across four transfers, and neither sees pready while the other is granted.
4. Completer returns PSLVERR=1 on a requester 1 write -> s_pslverr[1]=1 for one cycle coincident with s_pready[1]; s_pslverr[0] stays 0.
5. core_rst asserted during ACCESS -> next cycle m_psel=0, m_penable=0, all s_pready=0. After release with both requesting, requester 0 is granted first.
6. Macro on, TIMEOUT_CYCLES=16, completer never ready -> after 16 ACCESS cycles s_pready=1, s_pslverr=1, prdata=0. Macro off -> still in ACCESS after 1000 cycles.
